// File: rtl/spi_pkg.sv
// spi_pkg: types and defaults shared by the SPI transfer-queue slice.
//   xq_state_t : issue-controller states
//   XQ_WORD_W  : default SPI word width
package spi_pkg;

    localparam int unsigned XQ_WORD_W = 8;

    typedef enum logic [1:0] {
        XQ_IDLE,
        XQ_ISSUE,
        XQ_WAIT_DONE
    } xq_state_t;

endpackage

// File: rtl/spi_xfer_queue_if.sv
// spi_xfer_queue_if: handshake between the transfer queue and the SPI transfer FSM.
//   fsm_start / fsm_tx_data / fsm_tx_data_valid : queue -> FSM word issue
//   fsm_busy / fsm_done / fsm_rx_data / fsm_rx_data_valid : FSM -> queue status and received word
//   modport master : queue side
//   modport slave  : FSM side
interface spi_xfer_queue_if
    import spi_pkg::*;
#(
    parameter int unsigned WORD_W = XQ_WORD_W
);
    logic              fsm_start;
    logic [WORD_W-1:0] fsm_tx_data;
    logic              fsm_tx_data_valid;
    logic              fsm_busy;
    logic              fsm_done;
    logic [WORD_W-1:0] fsm_rx_data;
    logic              fsm_rx_data_valid;

    modport master (
        output fsm_start, fsm_tx_data, fsm_tx_data_valid,
        input  fsm_busy, fsm_done, fsm_rx_data, fsm_rx_data_valid
    );

    modport slave (
        input  fsm_start, fsm_tx_data, fsm_tx_data_valid,
        output fsm_busy, fsm_done, fsm_rx_data, fsm_rx_data_valid
    );
endinterface

// File: rtl/spi_sync_fifo.sv
// spi_sync_fifo: single-clock show-ahead FIFO used for both TX and RX queues.
//   push/wdata : write (ignored when full)
//   pop        : read  (ignored when empty)
//   rdata      : current head
//   full/empty/level : occupancy status
module spi_sync_fifo
    import spi_pkg::*;
#(
    parameter int unsigned WORD_W = XQ_WORD_W,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WORD_W-1:0]          wdata,
    output logic [WORD_W-1:0]          rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] level
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = $clog2(DEPTH + 1);

    // One extra pointer bit distinguishes full from empty when the index bits match.
    logic [AW:0]       wr_ptr_q, rd_ptr_q;
    logic [WORD_W-1:0] mem_q [DEPTH];
    logic              do_push, do_pop;

    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign level   = LW'(wr_ptr_q - rd_ptr_q);
    assign rdata   = mem_q[rd_ptr_q[AW-1:0]];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q[AW-1:0]] <= wdata;
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end
endmodule

// File: rtl/spi_xfer_queue.sv
// spi_xfer_queue: host word queue in front of the SPI transfer FSM.
//   Host side : spi_en, tx_wdata/tx_push/tx_full/tx_level, rx_rdata/rx_pop/rx_empty/rx_level,
//               tx_ovf, err_timeout, clr_err, xq_busy
//   FSM side  : fsm (spi_xfer_queue_if.master) start/data issue and done/rx capture
// Optional build macro SPI_XFER_QUEUE_TIMEOUT_EN adds a WAIT_DONE watchdog of TIMEOUT_CYC
// cycles; without it err_timeout is tied low and WAIT_DONE waits indefinitely.
module spi_xfer_queue
    import spi_pkg::*;
#(
    parameter int unsigned WORD_W      = XQ_WORD_W,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       spi_en,
    input  logic [WORD_W-1:0]          tx_wdata,
    input  logic                       tx_push,
    output logic                       tx_full,
    output logic [$clog2(DEPTH+1)-1:0] tx_level,
    output logic [WORD_W-1:0]          rx_rdata,
    input  logic                       rx_pop,
    output logic                       rx_empty,
    output logic [$clog2(DEPTH+1)-1:0] rx_level,
    output logic                       tx_ovf,
    output logic                       err_timeout,
    input  logic                       clr_err,
    output logic                       xq_busy,
    spi_xfer_queue_if.master           fsm
);
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_CYC < 2) begin : g_param_check
        $error("spi_xfer_queue: DEPTH must be a power of two >= 2 and TIMEOUT_CYC >= 2");
    end

    xq_state_t         state_q, state_d;
    logic              start_q, start_d;
    logic [WORD_W-1:0] tx_head, tx_hold_q;
    logic              tx_empty, rx_full;
    logic              tx_pop, capture, timeout_hit;
    logic              tx_ovf_q;

    spi_sync_fifo #(.WORD_W(WORD_W), .DEPTH(DEPTH)) u_tx_fifo (
        .clk(clk), .rst_n(rst_n), .push(tx_push), .pop(tx_pop), .wdata(tx_wdata),
        .rdata(tx_head), .full(tx_full), .empty(tx_empty), .level(tx_level)
    );

    spi_sync_fifo #(.WORD_W(WORD_W), .DEPTH(DEPTH)) u_rx_fifo (
        .clk(clk), .rst_n(rst_n), .push(capture), .pop(rx_pop), .wdata(fsm.fsm_rx_data),
        .rdata(rx_rdata), .full(rx_full), .empty(rx_empty), .level(rx_level)
    );

    assign tx_pop  = (state_q == XQ_ISSUE);
    assign capture = (state_q == XQ_WAIT_DONE) && fsm.fsm_done && fsm.fsm_rx_data_valid;
    assign xq_busy = (state_q != XQ_IDLE);

    // During ISSUE the word comes straight from the FIFO head; afterwards tx_hold keeps it
    // stable for the FSM's later load.
    assign fsm.fsm_tx_data       = (state_q == XQ_ISSUE) ? tx_head : tx_hold_q;
    assign fsm.fsm_start         = start_q;
    assign fsm.fsm_tx_data_valid = start_q;
    assign tx_ovf                = tx_ovf_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            XQ_IDLE: begin
                // Holding off on rx_full means a capture always has room.
                if (spi_en && !tx_empty && !rx_full && !fsm.fsm_busy) begin
                    state_d = XQ_ISSUE;
                end
            end
            XQ_ISSUE: state_d = XQ_WAIT_DONE;
            XQ_WAIT_DONE: begin
                if (capture || timeout_hit) begin
                    state_d = XQ_IDLE;
                end
            end
            default: state_d = XQ_IDLE;
        endcase
        start_d = (state_d == XQ_ISSUE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= XQ_IDLE;
            start_q   <= 1'b0;
            tx_hold_q <= '0;
            tx_ovf_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            start_q <= start_d;
            if (tx_pop) begin
                tx_hold_q <= tx_head;
            end
            // A new overflow outranks a simultaneous clear.
            if (tx_push && tx_full) begin
                tx_ovf_q <= 1'b1;
            end else if (clr_err) begin
                tx_ovf_q <= 1'b0;
            end
        end
    end

`ifdef SPI_XFER_QUEUE_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT_CYC);

    logic [CW-1:0] wd_cnt_q;
    logic          err_timeout_q;

    // A done on the final watchdog cycle is captured instead of timing out.
    assign timeout_hit = (state_q == XQ_WAIT_DONE) && !capture &&
                         (wd_cnt_q == CW'(TIMEOUT_CYC - 1));
    assign err_timeout = err_timeout_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt_q      <= '0;
            err_timeout_q <= 1'b0;
        end else begin
            if (state_q == XQ_WAIT_DONE) begin
                wd_cnt_q <= wd_cnt_q + 1'b1;
            end else begin
                wd_cnt_q <= '0;
            end
            if (timeout_hit) begin
                err_timeout_q <= 1'b1;
            end else if (clr_err) begin
                err_timeout_q <= 1'b0;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign err_timeout = 1'b0;
`endif
endmodule

// File: tb/tb_spi_xfer_queue.sv
// tb_spi_xfer_queue: self-checking bench for spi_xfer_queue with a behavioural SPI FSM
// responder (reply = issued word ^ 0x99 after a random latency) and queue-based model.
module tb_spi_xfer_queue;
    localparam int unsigned WORD_W      = 8;
    localparam int unsigned DEPTH       = 4;
    localparam int unsigned TIMEOUT_CYC = 16;
    localparam int unsigned LW          = $clog2(DEPTH + 1);

    logic              clk = 1'b0;
    logic              rst_n, spi_en, tx_push, rx_pop, clr_err;
    logic [WORD_W-1:0] tx_wdata, rx_rdata;
    logic              tx_full, rx_empty, tx_ovf, err_timeout, xq_busy;
    logic [LW-1:0]     tx_level, rx_level;

    logic              rsp_busy = 1'b0, rsp_done = 1'b0, inj_done = 1'b0;
    logic [WORD_W-1:0] rsp_data = '0, inj_data = '0;

    spi_xfer_queue_if #(.WORD_W(WORD_W)) fsm_if ();

    assign fsm_if.fsm_busy          = rsp_busy;
    assign fsm_if.fsm_done          = rsp_done | inj_done;
    assign fsm_if.fsm_rx_data_valid = rsp_done | inj_done;
    assign fsm_if.fsm_rx_data       = inj_done ? inj_data : rsp_data;

    spi_xfer_queue #(.WORD_W(WORD_W), .DEPTH(DEPTH), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .clk(clk), .rst_n(rst_n), .spi_en(spi_en), .tx_wdata(tx_wdata), .tx_push(tx_push),
        .tx_full(tx_full), .tx_level(tx_level), .rx_rdata(rx_rdata), .rx_pop(rx_pop),
        .rx_empty(rx_empty), .rx_level(rx_level), .tx_ovf(tx_ovf), .err_timeout(err_timeout),
        .clr_err(clr_err), .xq_busy(xq_busy), .fsm(fsm_if.master)
    );

    always #5 clk = ~clk;

    // Reference model: words the DUT should hold and the order they must appear.
    logic [WORD_W-1:0] exp_tx[$];
    logic [WORD_W-1:0] exp_rx[$];
    bit                exp_ovf = 1'b0;
    bit                rsp_en  = 1'b1;
    int                checks  = 0;
    int                errors  = 0;
    int                start_cnt = 0;
    logic              prev_busy = 1'b0;
    logic [WORD_W-1:0] mon_word, rsp_word;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Issue monitor: every start must carry the oldest queued word and follow an idle cycle.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && fsm_if.fsm_start) begin
                start_cnt++;
                checks++;
                if (exp_tx.size() == 0) begin
                    errors++;
                    $display("FAIL issue_unexpected data=%h", fsm_if.fsm_tx_data);
                end else begin
                    mon_word = exp_tx.pop_front();
                    if (fsm_if.fsm_tx_data !== mon_word || fsm_if.fsm_tx_data_valid !== 1'b1) begin
                        errors++;
                        $display("FAIL issue_data got=%h valid=%b exp=%h", fsm_if.fsm_tx_data,
                                 fsm_if.fsm_tx_data_valid, mon_word);
                    end
                end
                checks++;
                if (prev_busy !== 1'b0) begin
                    errors++;
                    $display("FAIL issue_gap prev_busy=%b exp=0", prev_busy);
                end
            end
            prev_busy = xq_busy;
        end
    end

    // Behavioural SPI FSM.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rsp_en && rst_n && fsm_if.fsm_start) begin
                rsp_word = fsm_if.fsm_tx_data;
                rsp_busy = 1'b1;
                repeat ($urandom_range(1, 4)) cyc();
                checks++;
                if (fsm_if.fsm_tx_data !== rsp_word) begin
                    errors++;
                    $display("FAIL tx_hold got=%h exp=%h", fsm_if.fsm_tx_data, rsp_word);
                end
                checks++;
                if (xq_busy !== 1'b1) begin
                    errors++;
                    $display("FAIL busy_wait got=%b exp=1", xq_busy);
                end
                rsp_data = rsp_word ^ 8'h99;
                rsp_done = 1'b1;
                exp_rx.push_back(rsp_word ^ 8'h99);
                cyc();
                rsp_done = 1'b0;
                rsp_busy = 1'b0;
                checks++;
                if (xq_busy !== 1'b0) begin
                    errors++;
                    $display("FAIL busy_fall got=%b exp=0", xq_busy);
                end
            end
        end
    end

    task automatic push_word(input logic [WORD_W-1:0] w);
        tx_wdata = w;
        tx_push  = 1'b1;
        if (exp_tx.size() < DEPTH) exp_tx.push_back(w);
        else exp_ovf = 1'b1;
        cyc();
        tx_push = 1'b0;
    endtask

    task automatic pop_rx(input string tag);
        logic [WORD_W-1:0] w;
        checks++;
        if (exp_rx.size() == 0) begin
            errors++;
            $display("FAIL %s_pop_unexpected rdata=%h", tag, rx_rdata);
        end else begin
            w = exp_rx.pop_front();
            if (rx_rdata !== w || rx_empty !== 1'b0) begin
                errors++;
                $display("FAIL %s_rdata got=%h empty=%b exp=%h", tag, rx_rdata, rx_empty, w);
            end
        end
        rx_pop = 1'b1;
        cyc();
        rx_pop = 1'b0;
    endtask

    task automatic wait_rx(input int n, input int budget, input string tag);
        int k;
        k = 0;
        while (rx_level !== LW'(n) && k < budget) begin
            cyc();
            k++;
        end
        checks++;
        if (rx_level !== LW'(n)) begin
            errors++;
            $display("FAIL %s_wait rx_level=%0d exp=%0d", tag, rx_level, n);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; spi_en = 1'b0; tx_push = 1'b0; rx_pop = 1'b0; clr_err = 1'b0;
        tx_wdata = '0;
        #23;
        checks++;
        if ({tx_full, tx_level, rx_empty, rx_level} !== {1'b0, LW'(0), 1'b1, LW'(0)}) begin
            errors++;
            $display("FAIL reset_fifo got=%b exp=%b", {tx_full, tx_level, rx_empty, rx_level},
                     {1'b0, LW'(0), 1'b1, LW'(0)});
        end
        checks++;
        if ({tx_ovf, err_timeout, xq_busy, fsm_if.fsm_start, fsm_if.fsm_tx_data_valid} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags got=%b exp=00000",
                     {tx_ovf, err_timeout, xq_busy, fsm_if.fsm_start, fsm_if.fsm_tx_data_valid});
        end
        checks++;
        if ({rx_rdata, fsm_if.fsm_tx_data} !== 16'h0000) begin
            errors++;
            $display("FAIL reset_data got=%h exp=0000", {rx_rdata, fsm_if.fsm_tx_data});
        end
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        checks++;
        if ({xq_busy, rx_empty, tx_level} !== {1'b0, 1'b1, LW'(0)}) begin
            errors++;
            $display("FAIL reset_release got=%b exp=%b", {xq_busy, rx_empty, tx_level},
                     {1'b0, 1'b1, LW'(0)});
        end
    endtask

    task automatic test_single();
        int s0;
        s0 = start_cnt;
        spi_en = 1'b1;
        push_word(8'hA5);
        wait_rx(1, 50, "single");
        checks++;
        if (start_cnt - s0 !== 1 || rx_rdata !== 8'h3C || tx_level !== LW'(0)) begin
            errors++;
            $display("FAIL single starts=%0d rdata=%h tx_level=%0d exp 1/3c/0",
                     start_cnt - s0, rx_rdata, tx_level);
        end
        pop_rx("single");
        checks++;
        if (rx_empty !== 1'b1) begin
            errors++;
            $display("FAIL single_empty got=%b exp=1", rx_empty);
        end
    endtask

    task automatic test_burst();
        int s0;
        spi_en = 1'b0;
        for (int i = 1; i <= 4; i++) push_word(WORD_W'(i));
        checks++;
        if (tx_full !== 1'b1 || tx_level !== LW'(DEPTH)) begin
            errors++;
            $display("FAIL burst_full full=%b level=%0d exp 1/%0d", tx_full, tx_level, DEPTH);
        end
        s0 = start_cnt;
        spi_en = 1'b1;
        wait_rx(4, 200, "burst");
        checks++;
        if (start_cnt - s0 !== 4 || tx_level !== LW'(0)) begin
            errors++;
            $display("FAIL burst_issues starts=%0d tx_level=%0d exp 4/0", start_cnt - s0, tx_level);
        end
        for (int i = 0; i < 4; i++) pop_rx("burst");
    endtask

    task automatic test_overflow();
        spi_en = 1'b0;
        for (int i = 0; i < 5; i++) push_word(WORD_W'($urandom));
        checks++;
        if (tx_level !== LW'(exp_tx.size()) || tx_ovf !== exp_ovf) begin
            errors++;
            $display("FAIL ovf_set level=%0d ovf=%b exp %0d/%b", tx_level, tx_ovf,
                     exp_tx.size(), exp_ovf);
        end
        clr_err = 1'b1;
        cyc();
        clr_err = 1'b0;
        exp_ovf = 1'b0;
        checks++;
        if (tx_ovf !== exp_ovf) begin
            errors++;
            $display("FAIL ovf_clear got=%b exp=%b", tx_ovf, exp_ovf);
        end
        clr_err = 1'b1;
        push_word(WORD_W'($urandom));
        clr_err = 1'b0;
        checks++;
        if (tx_ovf !== exp_ovf) begin
            errors++;
            $display("FAIL ovf_set_wins got=%b exp=%b", tx_ovf, exp_ovf);
        end
        clr_err = 1'b1;
        cyc();
        clr_err = 1'b0;
        exp_ovf = 1'b0;
        spi_en = 1'b1;
        wait_rx(4, 200, "ovf_drain");
        for (int i = 0; i < 4; i++) pop_rx("ovf");
        checks++;
        if (rx_empty !== 1'b1 || tx_level !== LW'(0) || tx_ovf !== 1'b0) begin
            errors++;
            $display("FAIL ovf_end empty=%b tx_level=%0d ovf=%b exp 1/0/0", rx_empty, tx_level, tx_ovf);
        end
    endtask

    task automatic test_rx_backpressure();
        int s0;
        spi_en = 1'b0;
        for (int i = 0; i < 4; i++) push_word(WORD_W'($urandom));
        spi_en = 1'b1;
        wait_rx(4, 200, "bp_fill");
        push_word(WORD_W'($urandom));
        push_word(WORD_W'($urandom));
        s0 = start_cnt;
        repeat (20) cyc();
        checks++;
        if (start_cnt !== s0 || tx_level !== LW'(2)) begin
            errors++;
            $display("FAIL bp_blocked starts=%0d tx_level=%0d exp 0/2", start_cnt - s0, tx_level);
        end
        pop_rx("bp");
        wait_rx(4, 50, "bp_one");
        repeat (10) cyc();
        checks++;
        if (start_cnt - s0 !== 1 || tx_level !== LW'(1)) begin
            errors++;
            $display("FAIL bp_one_issue starts=%0d tx_level=%0d exp 1/1", start_cnt - s0, tx_level);
        end
        for (int i = 0; i < 4; i++) pop_rx("bp_drain");
        wait_rx(1, 50, "bp_last");
        pop_rx("bp_last");
    endtask

    task automatic test_spi_en_drop();
        int s0, k;
        spi_en = 1'b0;
        push_word(WORD_W'($urandom));
        push_word(WORD_W'($urandom));
        s0 = start_cnt;
        spi_en = 1'b1;
        k = 0;
        while (xq_busy !== 1'b1 && k < 50) begin
            cyc();
            k++;
        end
        spi_en = 1'b0;
        repeat (20) cyc();
        checks++;
        if (rx_level !== LW'(1) || tx_level !== LW'(1) || start_cnt - s0 !== 1 || xq_busy !== 1'b0) begin
            errors++;
            $display("FAIL en_drop rx=%0d tx=%0d starts=%0d busy=%b exp 1/1/1/0",
                     rx_level, tx_level, start_cnt - s0, xq_busy);
        end
        spi_en = 1'b1;
        wait_rx(2, 100, "en_resume");
        pop_rx("en_drop");
        pop_rx("en_drop");
    endtask

    task automatic test_back_to_back();
        int n;
        spi_en = 1'b1;
        for (int r = 0; r < 10; r++) begin
            n = $urandom_range(1, 4);
            for (int i = 0; i < n; i++) push_word(WORD_W'($urandom));
            wait_rx(n, 200, "b2b");
            checks++;
            if (tx_level !== LW'(0)) begin
                errors++;
                $display("FAIL b2b_tx_level got=%0d exp=0", tx_level);
            end
            for (int i = 0; i < n; i++) pop_rx("b2b");
        end
        rx_pop = 1'b1;
        cyc();
        rx_pop = 1'b0;
        checks++;
        if (rx_level !== LW'(0) || rx_empty !== 1'b1) begin
            errors++;
            $display("FAIL pop_empty level=%0d empty=%b exp 0/1", rx_level, rx_empty);
        end
    endtask

`ifdef SPI_XFER_QUEUE_TIMEOUT_EN
    task automatic test_timeout();
        int k;
        rsp_en = 1'b0;
        spi_en = 1'b1;
        for (int pass = 0; pass < 2; pass++) begin
            push_word(WORD_W'($urandom));
            k = 0;
            while (fsm_if.fsm_start !== 1'b1 && k < 50) begin
                cyc();
                k++;
            end
            repeat (TIMEOUT_CYC) cyc();
            checks++;
            if (err_timeout !== 1'b0 || xq_busy !== 1'b1) begin
                errors++;
                $display("FAIL timeout_early err=%b busy=%b exp 0/1", err_timeout, xq_busy);
            end
            if (pass == 1) begin
                // done lands on the last watchdog cycle and must win
                inj_data = 8'h77;
                inj_done = 1'b1;
                exp_rx.push_back(8'h77);
            end
            cyc();
            inj_done = 1'b0;
            checks++;
            if (err_timeout !== (pass == 0) || xq_busy !== 1'b0 || rx_level !== LW'(pass)) begin
                errors++;
                $display("FAIL timeout_fire pass=%0d err=%b busy=%b rx=%0d", pass, err_timeout,
                         xq_busy, rx_level);
            end
            clr_err = 1'b1;
            cyc();
            clr_err = 1'b0;
            checks++;
            if (err_timeout !== 1'b0) begin
                errors++;
                $display("FAIL timeout_clear got=%b exp=0", err_timeout);
            end
        end
        pop_rx("timeout");
        rsp_en = 1'b1;
    endtask
`endif

    task automatic test_async_reset_mid();
        int k;
        rsp_en = 1'b0;
        spi_en = 1'b0;
        push_word(WORD_W'($urandom));
        push_word(WORD_W'($urandom));
        spi_en = 1'b1;
        k = 0;
        while (xq_busy !== 1'b1 && k < 50) begin
            cyc();
            k++;
        end
        repeat (3) cyc();
        #2;
        rst_n = 1'b0;
        exp_tx.delete();
        exp_rx.delete();
        exp_ovf = 1'b0;
        #1;
        checks++;
        if ({tx_full, tx_level, rx_empty, rx_level, xq_busy, err_timeout, tx_ovf} !==
            {1'b0, LW'(0), 1'b1, LW'(0), 3'b000}) begin
            errors++;
            $display("FAIL mid_reset got=%b exp=%b",
                     {tx_full, tx_level, rx_empty, rx_level, xq_busy, err_timeout, tx_ovf},
                     {1'b0, LW'(0), 1'b1, LW'(0), 3'b000});
        end
        checks++;
        if ({fsm_if.fsm_start, fsm_if.fsm_tx_data_valid, fsm_if.fsm_tx_data, rx_rdata} !== 18'h0) begin
            errors++;
            $display("FAIL mid_reset_data got=%h exp=0",
                     {fsm_if.fsm_start, fsm_if.fsm_tx_data_valid, fsm_if.fsm_tx_data, rx_rdata});
        end
        spi_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) cyc();
        checks++;
        if (xq_busy !== 1'b0 || tx_level !== LW'(0) || rx_level !== LW'(0)) begin
            errors++;
            $display("FAIL mid_reset_after busy=%b tx=%0d rx=%0d exp 0/0/0", xq_busy, tx_level, rx_level);
        end
        rsp_en = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation time limit");
    end

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_overflow();
        test_rx_backpressure();
        test_spi_en_drop();
        test_back_to_back();
`ifdef SPI_XFER_QUEUE_TIMEOUT_EN
        test_timeout();
`endif
        test_async_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
